irq_dispatch: RTL and testbench
===============================

Name: irq_dispatch

Overview:
- Sequences interrupt entry between the interrupt priority controller and the CPU core.
- Takes the winning request (index and priority) from the priority controller and gates it against the CPU interrupt mask (I01).
- Raises a level-coded request to the CPU, waits for the CPU's acknowledge at an instruction boundary, then fetches the 16-bit handler vector from the vector table over the shared bus and hands it to the CPU.

Parameters:
- VEC_BASE, 24'h000000, byte address of the vector table; entry n is at VEC_BASE + 2*n, little-endian.
- NMI_LAST, 5'd2, indices 0..NMI_LAST are non-maskable and bypass the I01 compare.
- BUS_TIMEOUT, 16, maximum cycles to wait for bus_rvalid after grant before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- irq_index  in  5  winning interrupt index from the priority controller
- irq_priority  in  2  winning priority; 0 means no request
- cpu_i01  in  2  CPU interrupt mask level
- cpu_ack  in  1  one-cycle pulse: CPU accepts the pending request
- cpu_irq  out  4  one-hot request level; bit 0 = NMI, bits 1..3 = priority
- bus_req  out  1  bus read request, held until bus_gnt
- bus_gnt  in  1  bus grant, single cycle
- bus_addr  out  24  read address, valid while bus_req is high
- bus_rdata  in  8  read data
- bus_rvalid  in  1  read data valid, single cycle
- vector  out  16  fetched handler address
- vector_valid  out  1  one-cycle pulse; vector is valid
- vec_index  out  5  index being serviced, stable from ack to vector_valid
- busy  out  1  high in every state except IDLE
- fetch_err  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset: state IDLE; all outputs 0; internal latches cleared. Reset mid-fetch aborts silently: no vector_valid, bus_req drops next cycle.
- Eligibility: eligible = irq_priority != 0 AND (irq_index <= NMI_LAST OR irq_priority > cpu_i01).
- Request coding: NMI (irq_index <= NMI_LAST) drives cpu_irq = 4'b0001. Otherwise cpu_irq[irq_priority] = 1 and all other bits are 0.
- IDLE: when eligible, latch index and priority and go to REQUEST. cpu_irq asserts the cycle after eligibility (1-cycle latency).
- REQUEST:
  - Latched index/priority track inputs each cycle while eligible.
  - If eligibility drops without cpu_ack, return to IDLE; cpu_irq clears next cycle.
  - On cpu_ack, freeze the index (inputs on the same cycle win), clear cpu_irq, go to FETCH_LO.
  - cpu_ack in any state other than REQUEST is ignored.
- FETCH_LO: bus_req = 1, bus_addr = VEC_BASE + {index,1'b0}. On bus_gnt, go to WAIT_LO. The timeout counter starts.
- WAIT_LO: on bus_rvalid, store the low byte and go to FETCH_HI.
- FETCH_HI / WAIT_HI: same handshake at bus_addr + 1; bus_rvalid stores the high byte and goes to DELIVER.
- DELIVER: vector_valid = 1 for one cycle with vector = {hi,lo}; return to IDLE. A new request may be raised on the following cycle.
- Timeout: the counter counts cycles in WAIT_* and resets on each grant. On reaching BUS_TIMEOUT, pulse fetch_err and return to IDLE with no vector.
- bus_gnt and bus_rvalid on the same cycle in FETCH_*: treat as grant plus data and skip WAIT_*.
- Address arithmetic: 24-bit, wraps modulo 2^24.
- vec_index is held from cpu_ack through DELIVER; 0 in IDLE.

Decomposition:
- Shared package irq_pkg holds:
  - enum dispatch_state_t {IDLE, REQUEST, FETCH_LO, WAIT_LO, FETCH_HI, WAIT_HI, DELIVER};
  - the IRQ_NUM = 32 constant;
  - the cpu_irq bit-position constants.
- One sub-module, irq_vec_fetch: two-byte bus read engine covering FETCH/WAIT and timeout, with a start/done/err interface. The dispatch FSM wraps it.

Test Plan:
- reset, then irq_index=5, priority=2, cpu_i01=1 -> cpu_irq=4'b0100 next cycle; cpu_ack -> bus reads at 0x00000A then 0x00000B; data 0x34, 0x12 -> vector=0x1234, vector_valid one cycle, busy drops.
- priority=1, cpu_i01=1, index=7 -> cpu_irq stays 0, busy stays 0. Same with index=1 (NMI) -> cpu_irq=4'b0001.
- In REQUEST, priority drops to 0 before ack -> cpu_irq=0 next cycle, state IDLE, no bus_req.
- After ack, bus_gnt but no bus_rvalid for 16 cycles -> fetch_err pulse, bus_req=0, no vector_valid.
- Reset asserted in WAIT_HI -> all outputs 0 next cycle; a later bus_rvalid is ignored.
- Index changes 5 -> 9 in REQUEST, then ack -> fetch addresses 0x000012/0x000013; vec_index=9.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt dispatch slice.
//   dispatch_state_t : dispatcher / vector-fetch phase encoding
//   IRQ_NUM, IDX_W   : interrupt source count and index width
//   CPU_IRQ_*        : bit positions of the one-hot CPU request level
//   irq_eligible()   : request gating against the CPU mask
//   irq_code()       : one-hot cpu_irq coding of a request
package irq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQUEST  = 3'd1,
    FETCH_LO = 3'd2,
    WAIT_LO  = 3'd3,
    FETCH_HI = 3'd4,
    WAIT_HI  = 3'd5,
    DELIVER  = 3'd6
  } dispatch_state_t;

  localparam int IRQ_NUM = 32;
  localparam int IDX_W   = $clog2(IRQ_NUM);
  localparam int PRI_W   = 2;

  localparam int CPU_IRQ_W    = 4;
  localparam int CPU_IRQ_NMI  = 0;
  localparam int CPU_IRQ_PRI1 = 1;
  localparam int CPU_IRQ_PRI2 = 2;
  localparam int CPU_IRQ_PRI3 = 3;

  // NMI sources ignore the mask; everything else must beat it strictly.
  function automatic logic irq_eligible(input logic [IDX_W-1:0] idx,
                                        input logic [PRI_W-1:0] pri,
                                        input logic [PRI_W-1:0] i01,
                                        input logic [IDX_W-1:0] nmi_last);
    return (pri != '0) && ((idx <= nmi_last) || (pri > i01));
  endfunction

  // Priority value doubles as the bit position for maskable sources.
  function automatic logic [CPU_IRQ_W-1:0] irq_code(input logic [IDX_W-1:0] idx,
                                                    input logic [PRI_W-1:0] pri,
                                                    input logic [IDX_W-1:0] nmi_last);
    logic [CPU_IRQ_W-1:0] one;
    one = 4'b0001;
    if (idx <= nmi_last) return one << CPU_IRQ_NMI;
    return one << pri;
  endfunction

endpackage

// File: rtl/irq_vec_fetch.sv
// irq_vec_fetch: two-byte little-endian vector read over the shared bus.
//   start_i        : one-cycle pulse, begin reading entry index_i
//   index_i        : vector table index, must stay stable until done/err
//   bus_*          : request/grant/data handshake to the shared bus
//   vec_o          : {hi,lo}, valid from the cycle after done_o
//   done_o / err_o : one-cycle completion / timeout pulses
module irq_vec_fetch
  import irq_pkg::*;
#(
  parameter logic [23:0] VEC_BASE    = 24'h000000,
  parameter int          BUS_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [IDX_W-1:0] index_i,
  output logic             bus_req_o,
  output logic [23:0]      bus_addr_o,
  input  logic             bus_gnt_i,
  input  logic [7:0]       bus_rdata_i,
  input  logic             bus_rvalid_i,
  output logic [15:0]      vec_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  dispatch_state_t  phase_q, phase_d;
  logic [7:0]       lo_q, lo_d, hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      lo_addr, hi_addr;

  // 24-bit sums wrap naturally.
  assign lo_addr = VEC_BASE + {18'd0, index_i, 1'b0};
  assign hi_addr = lo_addr + 24'd1;
  assign vec_o   = {hi_q, lo_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    unique case (phase_q)
      IDLE: if (start_i) phase_d = FETCH_LO;
      FETCH_LO: if (bus_gnt_i) begin
        cnt_d = '0;
        // Grant and data together skip the wait phase.
        if (bus_rvalid_i) begin
          lo_d    = bus_rdata_i;
          phase_d = FETCH_HI;
        end else begin
          phase_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (bus_rvalid_i) begin
          lo_d    = bus_rdata_i;
          phase_d = FETCH_HI;
        end else if (cnt_q == CNT_LAST) begin
          phase_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FETCH_HI: if (bus_gnt_i) begin
        cnt_d = '0;
        if (bus_rvalid_i) begin
          hi_d    = bus_rdata_i;
          phase_d = IDLE;
        end else begin
          phase_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus_rvalid_i) begin
          hi_d    = bus_rdata_i;
          phase_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          phase_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req_o  = 1'b0;
    bus_addr_o = '0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    unique case (phase_q)
      FETCH_LO: begin
        bus_req_o  = 1'b1;
        bus_addr_o = lo_addr;
      end
      FETCH_HI: begin
        bus_req_o  = 1'b1;
        bus_addr_o = hi_addr;
        done_o     = bus_gnt_i && bus_rvalid_i;
      end
      WAIT_LO: err_o = !bus_rvalid_i && (cnt_q == CNT_LAST);
      WAIT_HI: begin
        done_o = bus_rvalid_i;
        err_o  = !bus_rvalid_i && (cnt_q == CNT_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/irq_dispatch.sv
// irq_dispatch: interrupt entry sequencer between priority controller and CPU.
//   irq_index/irq_priority : winning request (priority 0 = none)
//   cpu_i01 / cpu_ack      : CPU mask level and request acknowledge pulse
//   cpu_irq                : one-hot request level (bit 0 NMI, 1..3 priority)
//   bus_*                  : vector table read port
//   vector/vector_valid    : fetched handler address and its strobe
//   vec_index              : index in service, 0 while idle
//   busy / fetch_err       : not-idle flag, bus timeout pulse
module irq_dispatch
  import irq_pkg::*;
#(
  parameter logic [23:0]      VEC_BASE    = 24'h000000,
  parameter logic [IDX_W-1:0] NMI_LAST    = 5'd2,
  parameter int               BUS_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     irq_index,
  input  logic [PRI_W-1:0]     irq_priority,
  input  logic [PRI_W-1:0]     cpu_i01,
  input  logic                 cpu_ack,
  output logic [CPU_IRQ_W-1:0] cpu_irq,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic [23:0]          bus_addr,
  input  logic [7:0]           bus_rdata,
  input  logic                 bus_rvalid,
  output logic [15:0]          vector,
  output logic                 vector_valid,
  output logic [IDX_W-1:0]     vec_index,
  output logic                 busy,
  output logic                 fetch_err
);

  dispatch_state_t  state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [PRI_W-1:0] pri_q, pri_d;
  logic             eligible;
  logic             fe_start, fe_done, fe_err;
  logic [15:0]      fe_vec;

  assign eligible = irq_eligible(irq_index, irq_priority, cpu_i01, NMI_LAST);

  // The engine owns the fine-grained FETCH/WAIT phases; here FETCH_LO
  // stands for the whole time the engine is running.
  irq_vec_fetch #(
    .VEC_BASE   (VEC_BASE),
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_fetch (
    .clk         (clk),
    .reset       (reset),
    .start_i     (fe_start),
    .index_i     (index_q),
    .bus_req_o   (bus_req),
    .bus_addr_o  (bus_addr),
    .bus_gnt_i   (bus_gnt),
    .bus_rdata_i (bus_rdata),
    .bus_rvalid_i(bus_rvalid),
    .vec_o       (fe_vec),
    .done_o      (fe_done),
    .err_o       (fe_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      pri_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      pri_q   <= pri_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    pri_d    = pri_q;
    fe_start = 1'b0;
    unique case (state_q)
      IDLE: if (eligible) begin
        index_d = irq_index;
        pri_d   = irq_priority;
        state_d = REQUEST;
      end
      REQUEST: begin
        // Same-cycle inputs win over the latched copy, also on ack.
        if (eligible) begin
          index_d = irq_index;
          pri_d   = irq_priority;
        end
        if (cpu_ack) begin
          fe_start = 1'b1;
          state_d  = FETCH_LO;
        end else if (!eligible) begin
          state_d = IDLE;
        end
      end
      FETCH_LO: begin
        if (fe_done)     state_d = DELIVER;
        else if (fe_err) state_d = IDLE;
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_irq      = '0;
    vector       = '0;
    vector_valid = 1'b0;
    vec_index    = '0;
    busy         = (state_q != IDLE);
    fetch_err    = (state_q == FETCH_LO) && fe_err;
    if (state_q == REQUEST) cpu_irq = irq_code(index_q, pri_q, NMI_LAST);
    if (state_q != IDLE)    vec_index = index_q;
    if (state_q == DELIVER) begin
      vector       = fe_vec;
      vector_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_dispatch.sv
module tb_irq_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  irq_index;
  logic [1:0]  irq_priority;
  logic [1:0]  cpu_i01;
  logic        cpu_ack;
  logic [3:0]  cpu_irq;
  logic        bus_req;
  logic        bus_gnt;
  logic [23:0] bus_addr;
  logic [7:0]  bus_rdata;
  logic        bus_rvalid;
  logic [15:0] vector;
  logic        vector_valid;
  logic [4:0]  vec_index;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  irq_dispatch dut (
    .clk(clk), .reset(reset),
    .irq_index(irq_index), .irq_priority(irq_priority),
    .cpu_i01(cpu_i01), .cpu_ack(cpu_ack), .cpu_irq(cpu_irq),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .vector(vector), .vector_valid(vector_valid), .vec_index(vec_index),
    .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_index = 0; irq_priority = 0; cpu_i01 = 0; cpu_ack = 0;
    bus_gnt = 0; bus_rdata = 0; bus_rvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    checks++;
    if ({cpu_irq, bus_req, bus_addr, vector, vector_valid, vec_index, busy, fetch_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: cpu_irq=%b bus_req=%b addr=%h vec=%h vv=%b idx=%0d busy=%b err=%b expected all 0",
               cpu_irq, bus_req, bus_addr, vector, vector_valid, vec_index, busy, fetch_err);
    end
  endtask

  task automatic test_basic_fetch();
    irq_index = 5; irq_priority = 2; cpu_i01 = 1;
    checks++;
    if (cpu_irq !== 4'b0000) begin failures++; $display("FAIL basic_irq_latency: got %b expected 0000", cpu_irq); end
    tick();
    checks++;
    if (cpu_irq !== 4'b0100 || busy !== 1'b1) begin
      failures++; $display("FAIL basic_irq: cpu_irq=%b busy=%b expected 0100/1", cpu_irq, busy);
    end
    cpu_ack = 1;
    tick();
    cpu_ack = 0; irq_priority = 0;
    checks++;
    if (cpu_irq !== 4'b0000 || bus_req !== 1'b1 || bus_addr !== 24'h00000A || vec_index !== 5'd5) begin
      failures++; $display("FAIL basic_fetch_lo: irq=%b req=%b addr=%h idx=%0d expected 0000/1/00000a/5",
                           cpu_irq, bus_req, bus_addr, vec_index);
    end
    bus_gnt = 1;
    tick();
    bus_gnt = 0;
    checks++;
    if (bus_req !== 1'b0) begin failures++; $display("FAIL basic_wait_lo_req: got %b expected 0", bus_req); end
    bus_rvalid = 1; bus_rdata = 8'h34;
    tick();
    bus_rvalid = 0;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 24'h00000B) begin
      failures++; $display("FAIL basic_fetch_hi: req=%b addr=%h expected 1/00000b", bus_req, bus_addr);
    end
    bus_gnt = 1;
    tick();
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 8'h12;
    tick();
    bus_rvalid = 0;
    checks++;
    if (vector_valid !== 1'b1 || vector !== 16'h1234 || vec_index !== 5'd5) begin
      failures++; $display("FAIL basic_deliver: vv=%b vec=%h idx=%0d expected 1/1234/5", vector_valid, vector, vec_index);
    end
    tick();
    checks++;
    if (vector_valid !== 1'b0 || busy !== 1'b0 || vec_index !== 5'd0) begin
      failures++; $display("FAIL basic_done: vv=%b busy=%b idx=%0d expected 0/0/0", vector_valid, busy, vec_index);
    end
  endtask

  task automatic test_mask_and_drop();
    irq_index = 7; irq_priority = 1; cpu_i01 = 1;
    tick(); tick();
    checks++;
    if (cpu_irq !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL masked: cpu_irq=%b busy=%b expected 0000/0", cpu_irq, busy);
    end
    // cpu_ack with nothing pending must not start anything
    cpu_ack = 1;
    tick();
    cpu_ack = 0;
    checks++;
    if (busy !== 1'b0 || bus_req !== 1'b0) begin
      failures++; $display("FAIL ack_idle: busy=%b req=%b expected 0/0", busy, bus_req);
    end
    irq_index = 1;
    tick();
    checks++;
    if (cpu_irq !== 4'b0001 || vec_index !== 5'd1) begin
      failures++; $display("FAIL nmi: cpu_irq=%b idx=%0d expected 0001/1", cpu_irq, vec_index);
    end
    irq_priority = 0;
    tick();
    checks++;
    if (cpu_irq !== 4'b0000 || busy !== 1'b0 || bus_req !== 1'b0) begin
      failures++; $display("FAIL drop: cpu_irq=%b busy=%b req=%b expected 0000/0/0", cpu_irq, busy, bus_req);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int err_at = 0;
    bit saw_vv = 0;
    irq_index = 3; irq_priority = 3; cpu_i01 = 0;
    tick();
    cpu_ack = 1;
    tick();
    cpu_ack = 0; irq_priority = 0;
    bus_gnt = 1;
    tick();
    bus_gnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (vector_valid) saw_vv = 1;
      if (fetch_err === 1'b1) begin err_at = k; break; end
      tick();
    end
    checks++;
    if (err_at != 16) begin failures++; $display("FAIL timeout_cycle: err seen at wait cycle %0d expected 16", err_at); end
    tick();
    checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0 || fetch_err !== 1'b0 || vector_valid !== 1'b0 || saw_vv) begin
      failures++; $display("FAIL timeout_after: req=%b busy=%b err=%b vv=%b saw_vv=%b expected all 0",
                           bus_req, busy, fetch_err, vector_valid, saw_vv);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit saw_vv = 0;
    irq_index = 4; irq_priority = 2; cpu_i01 = 0;
    tick();
    cpu_ack = 1;
    tick();
    cpu_ack = 0; irq_priority = 0;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 8'h55;
    tick();
    bus_rvalid = 0;
    tick();           // grant of the high byte, now waiting
    bus_gnt = 0;
    checks++;
    if (busy !== 1'b1 || bus_req !== 1'b0) begin
      failures++; $display("FAIL mid_setup: busy=%b req=%b expected 1/0", busy, bus_req);
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({cpu_irq, bus_req, bus_addr, vector, vector_valid, vec_index, busy, fetch_err} !== '0) begin
      failures++; $display("FAIL mid_reset: irq=%b req=%b addr=%h vv=%b idx=%0d busy=%b expected all 0",
                           cpu_irq, bus_req, bus_addr, vector_valid, vec_index, busy);
    end
    bus_rvalid = 1; bus_rdata = 8'hAA;
    tick();
    bus_rvalid = 0;
    for (int k = 0; k < 4; k++) begin
      if (vector_valid || busy) saw_vv = 1;
      tick();
    end
    checks++;
    if (saw_vv) begin failures++; $display("FAIL mid_late_rvalid: saw activity=1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    irq_index = 5; irq_priority = 2; cpu_i01 = 0;
    tick();
    irq_index = 9;
    tick();
    checks++;
    if (cpu_irq !== 4'b0100 || vec_index !== 5'd9) begin
      failures++; $display("FAIL track: irq=%b idx=%0d expected 0100/9", cpu_irq, vec_index);
    end
    cpu_ack = 1;
    tick();
    cpu_ack = 0;
    checks++;
    if (bus_addr !== 24'h000012 || bus_req !== 1'b1 || vec_index !== 5'd9) begin
      failures++; $display("FAIL track_lo: addr=%h req=%b idx=%0d expected 000012/1/9", bus_addr, bus_req, vec_index);
    end
    // grant and data together on both bytes
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 8'hCD;
    tick();
    checks++;
    if (bus_addr !== 24'h000013 || bus_req !== 1'b1) begin
      failures++; $display("FAIL track_hi: addr=%h req=%b expected 000013/1", bus_addr, bus_req);
    end
    bus_rdata = 8'hAB;
    tick();
    bus_gnt = 0; bus_rvalid = 0;
    checks++;
    if (vector_valid !== 1'b1 || vector !== 16'hABCD || vec_index !== 5'd9) begin
      failures++; $display("FAIL track_deliver: vv=%b vec=%h idx=%0d expected 1/abcd/9", vector_valid, vector, vec_index);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || vector_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_idle: busy=%b vv=%b expected 0/0", busy, vector_valid);
    end
    tick();
    checks++;
    if (cpu_irq !== 4'b0100 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_rerequest: irq=%b busy=%b expected 0100/1", cpu_irq, busy);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_mask_and_drop();
    test_timeout();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
